// File: rtl/wordline_burst_decoder_pkg.sv
// Shared definitions for the word-line burst decoder: FSM state encoding
// and the address-width to line-count derivation.
package wordline_burst_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_e;

    function automatic int nLines(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/wordline_burst_decoder_onehot_decoder.sv
// Generalised binary-to-one-hot word-line decoder with enable; all outputs
// are low when the enable is low.
module onehot_decoder
    import wordline_burst_decoder_pkg::*;
#(
    parameter  int ADDR_W  = 3,
    localparam int N_LINES = nLines(ADDR_W)
) (
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic               en_i,
    output logic [N_LINES-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/wordline_burst_decoder.sv
// Burst word-line sequencer: accepts a start address and beat count, then drives
// one-hot word lines with a configurable hold time and a guard cycle between lines.
module wordline_burst_decoder
    import wordline_burst_decoder_pkg::*;
#(
    parameter  int ADDR_W      = 3,
    parameter  int BURST_W     = 3,
    parameter  int HOLD_CYCLES = 1,
    localparam int N_LINES     = nLines(ADDR_W)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [BURST_W-1:0] req_len_i,
    input  logic               abort_i,
    output logic [N_LINES-1:0] line_sel_o,
    output logic [ADDR_W-1:0]  line_addr_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    curAddr_q, curAddr_d;
    logic [BURST_W-1:0]   beatsLeft_q, beatsLeft_d;
    logic [HOLD_W-1:0]    holdCnt_q, holdCnt_d;
    logic [N_LINES-1:0]   lineSel_q, lineSel_d;
    logic [ADDR_W-1:0]    lineAddr_q, lineAddr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 driveEn_d;
    logic                 accept;
    logic                 holdDone;

    // Abort wins over a simultaneous request.
    assign accept   = req_valid_i && (state_q == IDLE) && !abort_i;
    assign holdDone = (holdCnt_q == HOLD_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            curAddr_q   <= '0;
            beatsLeft_q <= '0;
            holdCnt_q   <= '0;
            lineSel_q   <= '0;
            lineAddr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            curAddr_q   <= curAddr_d;
            beatsLeft_q <= beatsLeft_d;
            holdCnt_q   <= holdCnt_d;
            lineSel_q   <= lineSel_d;
            lineAddr_q  <= lineAddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        curAddr_d   = curAddr_q;
        beatsLeft_d = beatsLeft_q;
        holdCnt_d   = holdCnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = DRIVE;
                    curAddr_d   = req_addr_i;
                    beatsLeft_d = req_len_i;
                    holdCnt_d   = '0;
                end
            end
            DRIVE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (holdDone) begin
                    state_d = (beatsLeft_q == '0) ? IDLE : GUARD;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            GUARD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d     = DRIVE;
                    curAddr_d   = curAddr_q + 1'b1;
                    beatsLeft_d = beatsLeft_q - 1'b1;
                    holdCnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        driveEn_d  = (state_d == DRIVE);
        busy_d     = (state_d != IDLE);
        lineAddr_d = driveEn_d ? curAddr_d : '0;
        done_d     = (state_q == DRIVE) && !abort_i && holdDone && (beatsLeft_q == '0);
    end

    onehot_decoder #(
        .ADDR_W(ADDR_W)
    ) uDecoder (
        .addr_i(curAddr_d),
        .en_i  (driveEn_d),
        .sel_o (lineSel_d)
    );

    assign req_ready_o = (state_q == IDLE);
    assign line_sel_o  = lineSel_q;
    assign line_addr_o = lineAddr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_wordline_burst_decoder.sv
// Bench for wordline_burst_decoder: two instances (hold 1 and hold 3) share stimulus and are
// checked every cycle against a cycle-offset model of the burst timeline.
module tb_wordline_burst_decoder;

    logic             clk;
    logic             reset;
    logic             reqValid;
    logic             abort;
    logic [2:0]       reqAddr;
    logic [2:0]       reqLen;
    logic [1:0]       reqReady;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][7:0]  lineSel;
    logic [1:0][2:0]  lineAddr;

    int vectors     = 0;
    int miscompares = 0;
    bit compareOn   = 0;

    wordline_burst_decoder #(.ADDR_W(3), .BURST_W(3), .HOLD_CYCLES(1)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(reqValid), .req_ready_o(reqReady[0]),
        .req_addr_i(reqAddr), .req_len_i(reqLen), .abort_i(abort),
        .line_sel_o(lineSel[0]), .line_addr_o(lineAddr[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    wordline_burst_decoder #(.ADDR_W(3), .BURST_W(3), .HOLD_CYCLES(3)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(reqValid), .req_ready_o(reqReady[1]),
        .req_addr_i(reqAddr), .req_len_i(reqLen), .abort_i(abort),
        .line_sel_o(lineSel[1]), .line_addr_o(lineAddr[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each burst is a timeline of (len+1)*(hold+1) cycles counted from acceptance;
    // the last cycle of that timeline is the done/idle cycle.
    bit mActive [2];
    int mJ      [2];
    int mAddr   [2];
    int mLen    [2];

    typedef struct packed {
        logic [7:0] sel;
        logic [2:0] addr;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    function automatic int holdOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int burstTotal(input int i);
        return (mLen[i] + 1) * (holdOf(i) + 1);
    endfunction

    function automatic bit modelReady(input int i);
        return !mActive[i] || (mJ[i] == burstTotal(i) - 1);
    endfunction

    function automatic exp_t modelOut(input int i);
        exp_t e;
        int   beat;
        int   phase;
        int   line;
        e       = '0;
        e.ready = 1'b1;
        if (mActive[i]) begin
            if (mJ[i] == burstTotal(i) - 1) begin
                e.done = 1'b1;
            end else begin
                e.ready = 1'b0;
                e.busy  = 1'b1;
                beat    = mJ[i] / (holdOf(i) + 1);
                phase   = mJ[i] % (holdOf(i) + 1);
                if (phase < holdOf(i)) begin
                    line   = (mAddr[i] + beat) % 8;
                    e.sel  = 8'(1 << line);
                    e.addr = 3'(line);
                end
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            rdy = modelReady(i);
            if (reset) begin
                mActive[i] = 1'b0;
            end else if (reqValid && rdy && !abort) begin
                mActive[i] = 1'b1;
                mJ[i]      = 0;
                mAddr[i]   = int'(reqAddr);
                mLen[i]    = int'(reqLen);
            end else if (mActive[i]) begin
                if (mJ[i] == burstTotal(i) - 1 || abort) begin
                    mActive[i] = 1'b0;
                end else begin
                    mJ[i] = mJ[i] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    logic [7:0] prevSel [2];

    always @(negedge clk) begin
        if (compareOn) begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                e = modelOut(i);
                checkOutput("line_sel",  i, 32'(lineSel[i]),  32'(e.sel));
                checkOutput("line_addr", i, 32'(lineAddr[i]), 32'(e.addr));
                checkOutput("busy",      i, 32'(busy[i]),     32'(e.busy));
                checkOutput("done",      i, 32'(done[i]),     32'(e.done));
                checkOutput("req_ready", i, 32'(reqReady[i]), 32'(e.ready));
                checkOutput("onehot",    i, 32'($countones(lineSel[i]) <= 1), 32'd1);
                checkOutput("no_b2b",    i,
                            32'(!(prevSel[i] != 8'h00 && lineSel[i] != 8'h00 && prevSel[i] != lineSel[i])), 32'd1);
                prevSel[i] = lineSel[i];
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [2:0] l, input logic ab);
        @(negedge clk);
        reqValid = v;
        reqAddr  = a;
        reqLen   = l;
        abort    = ab;
    endtask

    // Returns at the first negedge after the accepting edge (cycle T1).
    task automatic sendReq(input logic [2:0] a, input logic [2:0] l);
        applyStimulus(1'b1, a, l, 1'b0);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(reqReady == 2'b11 && busy == 2'b00)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                miscompares++;
                $display("[TB] FAIL waitIdle: still busy after %0d cycles, busy=%b ready=%b", n, busy, reqReady);
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] burstTbl [8];
        logic [7:0] holdTbl  [8];
        burstTbl = '{8'h40, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
        holdTbl  = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
        prevSel  = '{8'h00, 8'h00};
        reset    = 1'b1;
        reqValid = 1'b0;
        abort    = 1'b0;
        reqAddr  = '0;
        reqLen   = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_ready", i, 32'(reqReady[i]), 32'd1);
            checkOutput("reset_sel",   i, 32'(lineSel[i]),  32'd0);
            checkOutput("reset_busy",  i, 32'(busy[i]),     32'd0);
            checkOutput("reset_done",  i, 32'(done[i]),     32'd0);
        end
        compareOn = 1'b1;
        reset     = 1'b0;

        // Single beat at address 5.
        waitIdle();
        sendReq(3'd5, 3'd0);
        checkOutput("single_sel_T1",  0, 32'(lineSel[0]),  32'b0010_0000);
        checkOutput("single_addr_T1", 0, 32'(lineAddr[0]), 32'd5);
        @(negedge clk);
        checkOutput("single_sel_T2",   0, 32'(lineSel[0]),  32'd0);
        checkOutput("single_done_T2",  0, 32'(done[0]),     32'd1);
        checkOutput("single_ready_T2", 0, 32'(reqReady[0]), 32'd1);

        // Four-beat burst wrapping 7 -> 0.
        waitIdle();
        sendReq(3'd6, 3'd3);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            checkOutput("burst_sel", 0, 32'(lineSel[0]), 32'(burstTbl[k-1]));
        end
        checkOutput("burst_done_T8", 0, 32'(done[0]), 32'd1);

        // Hold time 3 on the second instance.
        waitIdle();
        sendReq(3'd2, 3'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            checkOutput("hold3_sel", 1, 32'(lineSel[1]), 32'(holdTbl[k-1]));
        end
        checkOutput("hold3_done_T8", 1, 32'(done[1]), 32'd1);

        // Abort during beat 2 of a four-beat burst.
        waitIdle();
        sendReq(3'd1, 3'd3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_beat2", 0, 32'(lineSel[0]), 32'h04);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_sel",   0, 32'(lineSel[0]),  32'd0);
        checkOutput("abort_busy",  0, 32'(busy[0]),     32'd0);
        checkOutput("abort_ready", 0, 32'(reqReady[0]), 32'd1);
        repeat (8) begin
            @(negedge clk);
            checkOutput("abort_no_done", 0, 32'(done[0]), 32'd0);
        end

        // Request held high while busy must not disturb the running burst.
        waitIdle();
        applyStimulus(1'b1, 3'd3, 3'd2, 1'b0);
        @(negedge clk);
        reqAddr = 3'd0;
        reqLen  = 3'd0;
        checkOutput("ignore_T1", 0, 32'(lineAddr[0]), 32'd3);
        @(negedge clk);
        checkOutput("ignore_T2", 0, 32'(lineSel[0]), 32'd0);
        @(negedge clk);
        checkOutput("ignore_T3", 0, 32'(lineAddr[0]), 32'd4);
        reqValid = 1'b0;

        // Reset in the middle of a burst.
        waitIdle();
        sendReq(3'd7, 3'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_mid_sel",  i, 32'(lineSel[i]),  32'd0);
            checkOutput("rst_mid_addr", i, 32'(lineAddr[i]), 32'd0);
            checkOutput("rst_mid_busy", i, 32'(busy[i]),     32'd0);
            checkOutput("rst_mid_done", i, 32'(done[i]),     32'd0);
        end

        // Address sweep, single beats.
        for (int a = 0; a < 8; a++) begin
            waitIdle();
            sendReq(3'(a), 3'd0);
        end

        // Random traffic including aborts, collisions with busy, and rare resets.
        repeat (600) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                          1'($urandom_range(0, 15) == 0));
            reset = ($urandom_range(0, 99) == 0);
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0);
        reset = 1'b0;
        waitIdle();
        @(negedge clk);
        compareOn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
